// File: rtl/pipe_control_unit.sv
// pipe_control_unit: decodes the ID opcode into a 10-bit control word and
// carries it through the ID/EX, EX/MEM and MEM/WB control registers, with
// freeze, branch-flush and load-use bubble handling plus saturating counters.
// Optional feature macro: PIPE_CTRL_LOADUSE_EN enables load-use detection
// and the stall counter; without it hazard_stall and stall_cnt are tied 0.
module pipe_control_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        opcode_id,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic              stall_ext,
  input  logic              flush,
  output logic [9:0]        ctrl_ex,
  output logic [9:0]        ctrl_mem,
  output logic [9:0]        ctrl_wb,
  output logic              hazard_stall,
  output logic              illegal_id,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_NOT   = 6'b111111;
  localparam logic [5:0] OP_BR2   = 6'b111110;
  localparam logic [5:0] OP_JUMP  = 6'b000010;

  // Bit order: Saltoincond, RegDest, FuenteALU, MemaReg, EscrReg,
  // LeerMem, EscrMem, SaltoCond, ALUOp[1:0]
  logic [9:0] ctrl_dec;
  logic       load_use;

  // Opcode decode; unknown opcodes become a bubble and are flagged
  always_comb begin
    ctrl_dec   = 10'b0000000000;
    illegal_id = 1'b0;
    case (opcode_id)
      OP_RTYPE: ctrl_dec = 10'b0100100010;
      OP_LW:    ctrl_dec = 10'b0011110000;
      OP_SW:    ctrl_dec = 10'b0010001000;
      OP_BEQ:   ctrl_dec = 10'b0000000101;
      OP_NOT:   ctrl_dec = 10'b0010100000;
      OP_BR2:   ctrl_dec = 10'b0000000101;
      OP_JUMP:  ctrl_dec = 10'b1000000000;
      default:  illegal_id = 1'b1;
    endcase
  end

`ifdef PIPE_CTRL_LOADUSE_EN
  logic [REG_AW-1:0] rt_ex;

  // A load in EX writing a register the ID instruction reads; jumps read no
  // registers, and register 0 never creates a dependency
  assign load_use = ctrl_ex[4] & ctrl_ex[5] & (rt_ex != '0)
                  & ((rt_ex == rs_id) | (rt_ex == rt_id))
                  & (opcode_id != OP_JUMP);

  // Destination of the EX instruction, cleared whenever a bubble enters EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rt_ex <= '0;
    end else if (!stall_ext) begin
      if (flush || load_use) rt_ex <= '0;
      else                   rt_ex <= rt_id;
    end
  end

  // Saturating count of inserted load-use bubbles (flush takes precedence)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!stall_ext && !flush && load_use && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`else
  // rs/rt only matter for hazard detection, which is compiled out here
  logic unused_id_fields;
  assign unused_id_fields = ^{rs_id, rt_id};
  assign load_use  = 1'b0;
  assign stall_cnt = '0;
`endif

  assign hazard_stall = load_use & ~flush & ~stall_ext;

  // Control pipeline: freeze holds, flush kills EX and MEM, load-use bubbles EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_ex  <= '0;
      ctrl_mem <= '0;
      ctrl_wb  <= '0;
    end else if (!stall_ext) begin
      if (flush) begin
        ctrl_ex  <= '0;
        ctrl_mem <= '0;
        ctrl_wb  <= ctrl_mem;
      end else if (load_use) begin
        ctrl_ex  <= '0;
        ctrl_mem <= ctrl_ex;
        ctrl_wb  <= ctrl_mem;
      end else begin
        ctrl_ex  <= ctrl_dec;
        ctrl_mem <= ctrl_ex;
        ctrl_wb  <= ctrl_mem;
      end
    end
  end

  // Saturating count of accepted flushes; a frozen flush is counted once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (!stall_ext && flush && (flush_cnt != '1)) begin
      flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_control_unit.sv
// Testbench for pipe_control_unit: scenario tasks plus a cycle scoreboard.
// A second instance with CNT_W=2 shares all inputs to exercise saturation.
module tb_pipe_control_unit;

`ifdef PIPE_CTRL_LOADUSE_EN
  localparam bit LU_EN = 1'b1;
`else
  localparam bit LU_EN = 1'b0;
`endif

  localparam logic [9:0] C_R    = 10'b0100100010;
  localparam logic [9:0] C_LW   = 10'b0011110000;
  localparam logic [9:0] C_SW   = 10'b0010001000;
  localparam logic [9:0] C_BEQ  = 10'b0000000101;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode_id;
  logic [4:0] rs_id, rt_id;
  logic       stall_ext, flush;
  logic [9:0] ctrl_ex, ctrl_mem, ctrl_wb;
  logic       hazard_stall, illegal_id;
  logic [15:0] stall_cnt, flush_cnt;
  logic [9:0] s_ex, s_mem, s_wb;
  logic       s_hs, s_ill;
  logic [1:0] s_sc, s_fc;

  int checks = 0;
  int errors = 0;

  pipe_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id),
    .stall_ext(stall_ext), .flush(flush), .ctrl_ex(ctrl_ex), .ctrl_mem(ctrl_mem),
    .ctrl_wb(ctrl_wb), .hazard_stall(hazard_stall), .illegal_id(illegal_id),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_control_unit #(.REG_AW(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id),
    .stall_ext(stall_ext), .flush(flush), .ctrl_ex(s_ex), .ctrl_mem(s_mem),
    .ctrl_wb(s_wb), .hazard_stall(s_hs), .illegal_id(s_ill),
    .stall_cnt(s_sc), .flush_cnt(s_fc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] ex, mem, wb;
    int         sc, fc;
    logic       hs, ill;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // Reference model state (post-edge view of the control registers)
  logic [9:0] m_ex, m_mem, m_wb;
  logic [4:0] m_rt;
  int         m_sc, m_fc;

  function automatic logic [10:0] ref_decode(input logic [5:0] op);
    case (op)
      6'b000000: return {1'b0, C_R};
      6'b100011: return {1'b0, C_LW};
      6'b101011: return {1'b0, C_SW};
      6'b000100: return {1'b0, C_BEQ};
      6'b111111: return {1'b0, 10'b0010100000};
      6'b111110: return {1'b0, 10'b0000000101};
      6'b000010: return {1'b0, 10'b1000000000};
      default:   return {1'b1, 10'b0};
    endcase
  endfunction

  function automatic bit ref_lu(input logic [9:0] ex, input logic [4:0] rt);
    return LU_EN && ex[4] && ex[5] && (rt != 0) && ((rt == rs_id) || (rt == rt_id))
           && (opcode_id != 6'b000010);
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Apply one clock edge to the model, queue the expectation, advance to
  // the next negedge+1 where the next stimulus is driven
  task automatic cyc();
    exp_t e;
    logic [10:0] d;
    bit lu;
    lu = ref_lu(m_ex, m_rt);
    d = ref_decode(opcode_id);
    if (!stall_ext) begin
      if (flush) begin
        m_wb = m_mem; m_mem = '0; m_ex = '0; m_rt = '0; m_fc++;
      end else if (lu) begin
        m_wb = m_mem; m_mem = m_ex; m_ex = '0; m_rt = '0; m_sc++;
      end else begin
        m_wb = m_mem; m_mem = m_ex; m_ex = d[9:0]; m_rt = rt_id;
      end
    end
    e.ex = m_ex; e.mem = m_mem; e.wb = m_wb; e.sc = m_sc; e.fc = m_fc;
    e.hs = ref_lu(m_ex, m_rt) && !flush && !stall_ext;
    e.ill = d[10];
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0; m_rt = '0; m_sc = 0; m_fc = 0;
    sb_q.delete();
  endtask

  // Scoreboard: compare each edge's outcome shortly after the edge
  always @(posedge clk) begin
    #2;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      if ({ctrl_ex, ctrl_mem, ctrl_wb} !== {mon_e.ex, mon_e.mem, mon_e.wb}) begin
        errors++;
        $display("FAIL sb_ctrl: got ex=%b mem=%b wb=%b expected ex=%b mem=%b wb=%b",
                 ctrl_ex, ctrl_mem, ctrl_wb, mon_e.ex, mon_e.mem, mon_e.wb);
      end
      checks++;
      if (stall_cnt !== 16'(LU_EN ? sat(mon_e.sc, 65535) : 0) ||
          flush_cnt !== 16'(sat(mon_e.fc, 65535))) begin
        errors++;
        $display("FAIL sb_cnt: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 stall_cnt, flush_cnt, LU_EN ? mon_e.sc : 0, mon_e.fc);
      end
      checks++;
      if (s_sc !== 2'(LU_EN ? sat(mon_e.sc, 3) : 0) || s_fc !== 2'(sat(mon_e.fc, 3)) ||
          s_ex !== mon_e.ex) begin
        errors++;
        $display("FAIL sb_sat: got stall=%0d flush=%0d ex=%b expected stall=%0d flush=%0d ex=%b",
                 s_sc, s_fc, s_ex, LU_EN ? sat(mon_e.sc, 3) : 0, sat(mon_e.fc, 3), mon_e.ex);
      end
      checks++;
      if (hazard_stall !== mon_e.hs || illegal_id !== mon_e.ill) begin
        errors++;
        $display("FAIL sb_comb: got hazard=%b illegal=%b expected hazard=%b illegal=%b",
                 hazard_stall, illegal_id, mon_e.hs, mon_e.ill);
      end
    end
  end

  task automatic set_in(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    opcode_id = op; rs_id = rs; rt_id = rt;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode_id = '0; rs_id = '0; rt_id = '0; stall_ext = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({ctrl_ex, ctrl_mem, ctrl_wb} !== 30'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b %b %b expected all zero", ctrl_ex, ctrl_mem, ctrl_wb);
    end
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt: got stall=%0d flush=%0d hazard=%b expected 0 0 0",
               stall_cnt, flush_cnt, hazard_stall);
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_decode();
    logic [5:0] ops  [7];
    logic [9:0] exps [7];
    ops  = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b111111, 6'b111110, 6'b000010};
    exps = '{C_R, C_LW, C_SW, C_BEQ, 10'b0010100000, 10'b0000000101, 10'b1000000000};
    for (int i = 0; i < 7; i++) begin
      set_in(ops[i], 5'd0, 5'd0);
      checks++;
      if (illegal_id !== 1'b0) begin
        errors++;
        $display("FAIL decode_legal[%0d]: got illegal=%b expected 0", i, illegal_id);
      end
      cyc();
      checks++;
      if (ctrl_ex !== exps[i]) begin
        errors++;
        $display("FAIL decode_ex[%0d]: got %b expected %b", i, ctrl_ex, exps[i]);
      end
      if (i == 2) begin
        checks++;
        if (ctrl_mem !== C_LW || ctrl_wb !== C_R) begin
          errors++;
          $display("FAIL decode_latency: got mem=%b wb=%b expected mem=%b wb=%b",
                   ctrl_mem, ctrl_wb, C_LW, C_R);
        end
      end
    end
    set_in(6'b001111, 5'd0, 5'd0);
    checks++;
    if (illegal_id !== 1'b1) begin
      errors++;
      $display("FAIL illegal_flag: got %b expected 1", illegal_id);
    end
    cyc();
    checks++;
    if (ctrl_ex !== 10'b0) begin
      errors++;
      $display("FAIL illegal_bubble: got %b expected 0000000000", ctrl_ex);
    end
  endtask

  task automatic test_load_use();
    set_in(6'b100011, 5'd0, 5'd5);
    cyc();
    set_in(6'b000000, 5'd5, 5'd1);
    checks++;
    if (hazard_stall !== LU_EN) begin
      errors++;
      $display("FAIL lu_stall: got %b expected %b", hazard_stall, LU_EN);
    end
    cyc();
    checks++;
    if (ctrl_ex !== (LU_EN ? 10'b0 : C_R)) begin
      errors++;
      $display("FAIL lu_bubble: got %b expected %b", ctrl_ex, LU_EN ? 10'b0 : C_R);
    end
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_one_cycle: got hazard=%b expected 0", hazard_stall);
    end
    cyc();
    checks++;
    if (ctrl_ex !== C_R || stall_cnt !== 16'(LU_EN ? 1 : 0)) begin
      errors++;
      $display("FAIL lu_resume: got ex=%b stall_cnt=%0d expected ex=%b stall_cnt=%0d",
               ctrl_ex, stall_cnt, C_R, LU_EN ? 1 : 0);
    end
    // load into r0 never stalls
    set_in(6'b100011, 5'd0, 5'd0);
    cyc();
    set_in(6'b000000, 5'd0, 5'd0);
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_r0: got %b expected 0", hazard_stall);
    end
    cyc();
    // jump after a load never stalls even with matching fields
    set_in(6'b100011, 5'd0, 5'd7);
    cyc();
    set_in(6'b000010, 5'd7, 5'd7);
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_jump: got %b expected 0", hazard_stall);
    end
    cyc();
  endtask

  task automatic test_flush();
    set_in(6'b000100, 5'd0, 5'd0);
    cyc();
    set_in(6'b000000, 5'd0, 5'd0);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    checks++;
    if (ctrl_ex !== 10'b0 || ctrl_mem !== 10'b0 || ctrl_wb !== C_BEQ || flush_cnt !== 16'd1) begin
      errors++;
      $display("FAIL flush_kill: got ex=%b mem=%b wb=%b cnt=%0d expected 0 0 %b 1",
               ctrl_ex, ctrl_mem, ctrl_wb, flush_cnt, C_BEQ);
    end
  endtask

  task automatic test_freeze();
    set_in(6'b100011, 5'd0, 5'd5);
    cyc();
    set_in(6'b000000, 5'd5, 5'd0);
    flush = 1'b1;
    stall_ext = 1'b1;
    #1;
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL freeze_hazard: got %b expected 0", hazard_stall);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (ctrl_ex !== C_LW || flush_cnt !== 16'd1 || stall_cnt !== 16'(LU_EN ? 1 : 0)) begin
        errors++;
        $display("FAIL freeze_hold[%0d]: got ex=%b flush_cnt=%0d stall_cnt=%0d expected %b 1 %0d",
                 i, ctrl_ex, flush_cnt, stall_cnt, C_LW, LU_EN ? 1 : 0);
      end
    end
    stall_ext = 1'b0;
    #1;
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_over_lu: got hazard=%b expected 0", hazard_stall);
    end
    cyc();
    flush = 1'b0;
    checks++;
    if (ctrl_ex !== 10'b0 || ctrl_mem !== 10'b0 || flush_cnt !== 16'd2 ||
        stall_cnt !== 16'(LU_EN ? 1 : 0)) begin
      errors++;
      $display("FAIL freeze_release: got ex=%b mem=%b flush_cnt=%0d stall_cnt=%0d expected 0 0 2 %0d",
               ctrl_ex, ctrl_mem, flush_cnt, stall_cnt, LU_EN ? 1 : 0);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      set_in(6'b100011, 5'd0, 5'd3);
      cyc();
      set_in(6'b000000, 5'd3, 5'd0);
      cyc();
      cyc();
    end
    checks++;
    if (s_sc !== 2'(LU_EN ? 3 : 0) || stall_cnt !== 16'(LU_EN ? 6 : 0)) begin
      errors++;
      $display("FAIL stall_saturate: got narrow=%0d wide=%0d expected %0d %0d",
               s_sc, stall_cnt, LU_EN ? 3 : 0, LU_EN ? 6 : 0);
    end
  endtask

  task automatic test_reset_mid();
    set_in(6'b000000, 5'd0, 5'd0);
    cyc();
    set_in(6'b101011, 5'd0, 5'd0);
    cyc();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({ctrl_ex, ctrl_mem, ctrl_wb, s_ex, s_mem, s_wb} !== 60'b0) begin
      errors++;
      $display("FAIL midreset_ctrl: got %b %b %b expected all zero", ctrl_ex, ctrl_mem, ctrl_wb);
    end
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || s_sc !== 2'd0 || s_fc !== 2'd0 ||
        hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL midreset_cnt: got stall=%0d flush=%0d hazard=%b expected 0 0 0",
               stall_cnt, flush_cnt, hazard_stall);
    end
    #1;
    rst_n = 1'b1;
    set_in(6'b000000, 5'd0, 5'd0);
    cyc();
    checks++;
    if (ctrl_ex !== C_R || ctrl_mem !== 10'b0) begin
      errors++;
      $display("FAIL after_reset: got ex=%b mem=%b expected %b 0", ctrl_ex, ctrl_mem, C_R);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_decode();
    test_load_use();
    test_flush();
    test_freeze();
    test_saturation();
    test_reset_mid();
    repeat (2) @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_control_unit.md
# pipe_control_unit

Parametrised successor to the single-cycle opcode decoder in the segmented processor. It decodes the 6-bit opcode in ID into the 10-bit control word and carries that word through the ID/EX, EX/MEM and MEM/WB control registers. It also handles external freeze, branch flush and load-use hazard bubbles, and keeps saturating stall and flush counters. It sits beside the datapath pipeline registers, and each stage takes its control fields from the matching output.

## Interface
Parameters:
- REG_AW, 5: register-address width.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- opcode_id  in  6: opcode of the instruction in ID.
- rs_id  in  REG_AW: rs field of the ID instruction.
- rt_id  in  REG_AW: rt field of the ID instruction.
- stall_ext  in  1: global freeze request, e.g. memory wait.
- flush  in  1: branch or jump taken, resolved in MEM.
- ctrl_ex  out  10: control word in EX (registered).
- ctrl_mem  out  10: control word in MEM (registered).
- ctrl_wb  out  10: control word in WB (registered).
- hazard_stall  out  1: hold PC and IF/ID this cycle (combinational).
- illegal_id  out  1: opcode_id is not in the decode table (combinational).
- stall_cnt  out  CNT_W: count of load-use bubble cycles.
- flush_cnt  out  CNT_W: count of accepted flushes.

## Operation
- Control word bits, MSB to LSB: [9] Saltoincond, [8] RegDest, [7] FuenteALU, [6] MemaReg, [5] EscrReg, [4] LeerMem, [3] EscrMem, [2] SaltoCond, [1:0] ALUOp.
- Decode table:
  - 000000 (R-type): 0100100010.
  - 100011 (lw): 0011110000.
  - 101011 (sw): 0010001000.
  - 000100 (beq): 0000000101.
  - 111111 (not): 0010100000.
  - 111110: 0000000101.
  - 000010 (jump): 1000000000.
  - Any other opcode: 0000000000 (bubble) with illegal_id=1.
- Internal register rt_ex (REG_AW bits) travels with ctrl_ex.
- Load-use condition:
  - ctrl_ex[4] & ctrl_ex[5] & (rt_ex != 0)
  - & ((rt_ex == rs_id) | (rt_ex == rt_id))
  - & (opcode_id != 000010).
- Per-edge update, in priority order:
  - stall_ext=1: every register and counter holds.
  - flush=1: ctrl_ex<=0, rt_ex<=0, ctrl_mem<=0, ctrl_wb<=ctrl_mem. flush_cnt increments. A load-use condition in the same cycle is ignored.
  - Load-use: ctrl_ex<=0, rt_ex<=0, ctrl_mem<=ctrl_ex, ctrl_wb<=ctrl_mem. stall_cnt increments.
  - Otherwise: ctrl_ex<=decode(opcode_id), rt_ex<=rt_id, ctrl_mem<=ctrl_ex, ctrl_wb<=ctrl_mem.
- hazard_stall = load-use condition & !flush & !stall_ext.
- Both counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- Reset, asynchronous: ctrl_ex, ctrl_mem, ctrl_wb, rt_ex, stall_cnt and flush_cnt all become 0, so hazard_stall=0. Reset asserted mid-operation discards all in-flight control immediately.
- Latency: an opcode presented in ID at edge N appears on ctrl_ex after edge N, on ctrl_mem after N+1 and on ctrl_wb after N+2.
- Load-use: hazard_stall is 1 for exactly one cycle per load-dependent instruction. The datapath holds IF/ID, the same opcode is re-presented and decodes normally on the next edge.
- Flush and stall_ext together: the freeze wins. The flush must be held until stall_ext drops, and is counted once.
- illegal_id and hazard_stall are combinational from the current-cycle inputs and registers. No clock-gating is used.

## Configuration
- Macro PIPE_CTRL_LOADUSE_EN.
- Defined: load-use detection and stall_cnt operate as described above.
- Undefined:
  - hazard_stall is tied 0.
  - stall_cnt is tied 0.
  - rt_ex is removed.
  - Software must insert a nop after every lw.

## Test plan
- Reset release, then opcodes 000000, 100011, 101011 on three consecutive cycles: ctrl_ex shows 0100100010, 0011110000, 0010001000 in turn, and ctrl_wb shows 0100100010 two cycles after it first appeared on ctrl_ex.
- lw with rt=5, then R-type with rs=5: hazard_stall=1 for one cycle; ctrl_ex=0 on the next edge; the R-type decodes on the following edge; stall_cnt=1. Repeat with rt=0: no stall.
- beq reaches MEM, flush=1 for one cycle: ctrl_ex=0 and ctrl_mem=0 next; ctrl_wb=0000000101; flush_cnt=1.
- stall_ext=1 for 3 cycles with a flush and a load-use condition pending: all outputs and counters frozen. After release the flush is taken and the load-use is suppressed.
- Opcode 001111: illegal_id=1 and ctrl_ex=0 next edge. Pulse rst_n low mid-stream: all outputs read 0 within the same cycle.
- CNT_W=2, force 5 load-use stalls: stall_cnt reads 3 and does not wrap.
